multimode_seq_unit: RTL
=======================

MULTIMODE_SEQ_UNIT -- requirements
Module: multimode_seq_unit

Interface
REQ-001 Parameter WIDTH, default 8: core register and data width, legal range 4..16.
REQ-002 Parameter LFSR_TAPS, default 8'hB8: Galois feedback mask, WIDTH bits wide.
REQ-003 Parameter LFSR_SEED, default 8'h01: LFSR initial state; SHALL be nonzero.
REQ-004 Port clk, input, 1: the single clock, rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port mode, input, 2: operating mode select. 00 = shift, 01 = counter, 10 = LFSR, 11 = detector.
REQ-007 Port enable, input, 1: advance the core by one step.
REQ-008 Port serial_in, input, 1: serial bit used in shift and detector modes.
REQ-009 Port load, input, 1: parallel load strobe.
REQ-010 Port load_data, input, WIDTH: parallel load value.
REQ-011 Port data_out, output, WIDTH: core register. In detector mode this is the history register.
REQ-012 Port match, output, 1: registered single-cycle event pulse.
REQ-013 Port match_count, output, 8: saturating count of match pulses.

Function
REQ-014 The block SHALL register mode internally as mode_q. When mode differs from mode_q at a clock edge:
- mode_q updates.
- The core takes the new mode's init value: shift 0, counter 0, LFSR LFSR_SEED, detector history 0 with fill count 0.
- match_count clears and match is 0.
- load and enable are ignored that cycle.
REQ-015 Priority per edge SHALL be: mode change, then load, then enable.
REQ-016 Load in shift or counter mode SHALL set core <= load_data.
REQ-017 Load in LFSR mode SHALL set core <= load_data, or LFSR_SEED if load_data is 0. The all-zero state is unreachable.
REQ-018 Load in detector mode SHALL write the pattern register (reset value 0), clear the history and clear the fill count.
REQ-019 Shift + enable SHALL set core <= {core[WIDTH-2:0], serial_in}; match stays 0.
REQ-020 Counter + enable SHALL set core <= core+1, wrapping all-ones to 0. match = 1 in the cycle data_out becomes 0 through a wrap.
REQ-021 LFSR + enable SHALL set core <= (core >> 1) XOR (core[0] ? LFSR_TAPS : 0). match = 1 in the cycle data_out equals LFSR_SEED after a step.
REQ-022 Detector + enable SHALL:
- shift serial_in into the history, LSB side;
- increment the fill count, saturating at WIDTH;
- assert match next cycle iff the post-shift fill = WIDTH and the post-shift history = pattern.
Overlapping matches are detected.
REQ-023 match SHALL be 0 in any cycle without an enabled step; maximum pulse width is 1 cycle per step.
REQ-024 match_count SHALL increment on every match pulse in any mode and saturate at 255.
REQ-025 Outputs SHALL be registered, with no combinational path from inputs to outputs. Latency is 1 clock from the sampling edge.

Reset
REQ-026 While reset is high, asynchronously:
- mode_q = 00, data_out = 0, match = 0, match_count = 0, pattern = 0, fill = 0.
- The first post-reset edge with mode ≠ 00 is treated as a mode change.
REQ-027 Reset asserted mid-operation SHALL take effect without a clock. The pattern register is lost.

Structure
REQ-028 A shared package seq_unit_pkg SHALL hold the mode encodings (MODE_SHIFT, MODE_COUNT, MODE_LFSR, MODE_DETECT) and the default taps and seed.
REQ-029 Detector history, fill count and compare SHALL live in one sub-module, seq_pattern_match.
REQ-030 Core, mode_q, match and match_count SHALL be in the top level. Implementation target is 120–400 lines.

Verification
REQ-031 Counter: load 8'hFE, then 2 enables -> data_out FF then 00. match = 1 only on the 00 cycle; match_count = 1.
REQ-032 LFSR: after a mode change to 10 -> data_out 01; first step -> B8. Exactly 255 steps return to 01 with a single match pulse, and 00 never appears.
REQ-033 Detector: load pattern A5, feed 1,0,1,0,0,1,0,1 -> match after the 8th bit only. Pattern AA, feed 1010101010 -> matches after bits 8 and 10; match_count = 2.
REQ-034 Shift mode, data_out 3C; switch mode to 10 with load = 1, enable = 1 the same edge -> data_out 01; load ignored; match_count 0.
REQ-035 Counter enabled 10 cycles (data_out 0A, match_count nonzero from earlier), then reset pulsed between edges -> data_out 00 and match_count 0 immediately.
REQ-036 Counter at FF, 300 wraps -> match_count holds 255.

Source files
------------

// File: rtl/seq_unit_pkg.sv
// Shared mode encodings and default LFSR constants for the multimode sequence unit.
package seq_unit_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'b00,
    MODE_COUNT  = 2'b01,
    MODE_LFSR   = 2'b10,
    MODE_DETECT = 2'b11
  } mode_e;

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned COUNT_W = 8;

  localparam logic [7:0] DEFAULT_TAPS = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'h01;

endpackage : seq_unit_pkg

// File: rtl/multimode_seq_unit_if.sv
// Control/data bundle between a driver and the multimode sequence unit.
interface multimode_seq_unit_if #(
  parameter int unsigned WIDTH = 8
);
  import seq_unit_pkg::*;

  logic [MODE_W-1:0]  mode;
  logic               enable;
  logic               serial_in;
  logic               load;
  logic [WIDTH-1:0]   load_data;
  logic [WIDTH-1:0]   data_out;
  logic               match;
  logic [COUNT_W-1:0] match_count;

  modport master (
    output mode, enable, serial_in, load, load_data,
    input  data_out, match, match_count
  );

  modport slave (
    input  mode, enable, serial_in, load, load_data,
    output data_out, match, match_count
  );

endinterface : multimode_seq_unit_if

// File: rtl/seq_pattern_match.sv
// Detector datapath: serial history, saturating fill count and pattern compare.
module seq_pattern_match #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] history,
  output logic             hit_c
);

  localparam int unsigned         FILL_W    = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0]   FILL_FULL = FILL_W'(WIDTH);

  logic [WIDTH-1:0]  pattern_q, pattern_d;
  logic [WIDTH-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
    end
  end

  // clear (mode change) wins over load, load wins over a step
  always_comb begin
    pattern_d = pattern_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    hit_c     = 1'b0;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (load) begin
      pattern_d = load_data;
      hist_d    = '0;
      fill_d    = '0;
    end else if (step) begin
      hist_d = {hist_q[WIDTH-2:0], serial_in};
      fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
      hit_c  = (fill_d == FILL_FULL) && (hist_d == pattern_q);
    end
  end

  assign history = hist_q;

endmodule : seq_pattern_match

// File: rtl/multimode_seq_unit.sv
// Multimode sequencer: shift register, counter, Galois LFSR or serial pattern detector
// with a registered match pulse and a saturating match counter.
module multimode_seq_unit
  import seq_unit_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(DEFAULT_TAPS),
  parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'(DEFAULT_SEED)
) (
  input logic                 clk,
  input logic                 reset,
  multimode_seq_unit_if.slave bus
);

  mode_e              mode_q, mode_d, mode_in;
  logic [WIDTH-1:0]   core_q, core_d;
  logic               match_q, match_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]   lfsr_next;
  logic [WIDTH-1:0]   pm_history;
  logic               mode_chg, pm_load, pm_step, pm_hit;

  assign mode_in   = mode_e'(bus.mode);
  assign mode_chg  = (mode_in != mode_q);
  assign lfsr_next = (core_q >> 1) ^ (core_q[0] ? LFSR_TAPS : '0);

  // Detector strobes decoded outside the main comb block to keep the hit path acyclic
  assign pm_load = !mode_chg && bus.load && (mode_q == MODE_DETECT);
  assign pm_step = !mode_chg && !bus.load && bus.enable && (mode_q == MODE_DETECT);

  seq_pattern_match #(
    .WIDTH (WIDTH)
  ) u_match (
    .clk       (clk),
    .reset     (reset),
    .clear     (mode_chg),
    .load      (pm_load),
    .step      (pm_step),
    .serial_in (bus.serial_in),
    .load_data (bus.load_data),
    .history   (pm_history),
    .hit_c     (pm_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= MODE_SHIFT;
      core_q  <= '0;
      match_q <= 1'b0;
      count_q <= '0;
    end else begin
      mode_q  <= mode_d;
      core_q  <= core_d;
      match_q <= match_d;
      count_q <= count_d;
    end
  end

  // Priority: mode change, then load, then enabled step
  always_comb begin
    mode_d  = mode_in;
    core_d  = core_q;
    match_d = 1'b0;
    count_d = count_q;
    if (mode_chg) begin
      core_d  = (mode_in == MODE_LFSR) ? LFSR_SEED : '0;
      count_d = '0;
    end else if (bus.load) begin
      unique case (mode_q)
        MODE_SHIFT, MODE_COUNT: core_d = bus.load_data;
        MODE_LFSR:              core_d = (bus.load_data == '0) ? LFSR_SEED : bus.load_data;
        MODE_DETECT:            core_d = core_q;
      endcase
    end else if (bus.enable) begin
      unique case (mode_q)
        MODE_SHIFT: core_d = {core_q[WIDTH-2:0], bus.serial_in};
        MODE_COUNT: begin
          core_d  = core_q + WIDTH'(1);
          match_d = &core_q;
        end
        MODE_LFSR: begin
          core_d  = lfsr_next;
          match_d = (lfsr_next == LFSR_SEED);
        end
        MODE_DETECT: match_d = pm_hit;
      endcase
    end
    if (match_d && (count_q != '1)) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  // In detector mode the visible core is the history register
  assign bus.data_out    = (mode_q == MODE_DETECT) ? pm_history : core_q;
  assign bus.match       = match_q;
  assign bus.match_count = count_q;

endmodule : multimode_seq_unit
